// File: rtl/rvga_types.sv
// Shared membus types: address width, default cacheline type and responder FSM states.
package rvga_types;

    localparam int unsigned MEMBUS_ADDR_W  = 32;
    localparam int unsigned CACHELINE_BITS = 256;

    typedef logic [MEMBUS_ADDR_W-1:0]  membus_addr_t;
    typedef logic [CACHELINE_BITS-1:0] cacheline_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } membus_state_e;

endpackage

// File: rtl/membus_mem_array.sv
// Line storage: one synchronous write port and one synchronous read port.
// Only the read-data register is reset; the array contents survive reset.
module membus_mem_array #(
    parameter int unsigned Width = 256,
    parameter int unsigned Depth = 1024,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AddrW-1:0] i_waddr,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AddrW-1:0] i_raddr,
    output logic [Width-1:0] o_rdata
);

    logic [Width-1:0] r_mem [Depth];
    logic [Width-1:0] r_rdata;

    // Array write; no reset so contents are preserved across rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read data register: updates only on a read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/membus_mem_responder.sv
// Membus line memory responder: accepts one read/write line request at a time and
// answers after a fixed latency with a single-cycle resp pulse.
// Optional protocol checker enabled by defining MEMBUS_PROTO_CHECK_EN.
module membus_mem_responder
    import rvga_types::*;
#(
    parameter int unsigned line_bits   = CACHELINE_BITS,
    parameter int unsigned depth_lines = 1024,
    parameter int unsigned latency     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  membus_addr_t         membus_addr_i,
    input  logic                 membus_read_i,
    input  logic                 membus_write_i,
    input  logic [line_bits-1:0] membus_wdata_i,
    output logic [line_bits-1:0] membus_rdata_o,
    output logic                 membus_resp_o,
    output logic                 proto_err_o
);

    localparam int unsigned OffW = $clog2(line_bits / 8);
    localparam int unsigned IdxW = $clog2(depth_lines);
    localparam int unsigned CntW = $clog2(latency + 1);

    membus_state_e        r_state;
    membus_state_e        w_state_next;
    logic [CntW-1:0]      r_cnt;
    logic [CntW-1:0]      w_cnt_next;
    membus_addr_t         r_addr;
    logic [line_bits-1:0] r_wdata;
    logic                 r_is_wr;

    logic                 w_req;
    logic                 w_accept;
    logic                 w_enter_resp;
    logic                 w_op_wr;
    logic [IdxW-1:0]      w_idx;
    logic [line_bits-1:0] w_wdata;
    logic                 w_unused_addr;

    assign w_req    = membus_read_i | membus_write_i;
    assign w_accept = (r_state == StIdle) && w_req;

    // With latency=1 the commit happens on the accept edge, before anything is latched,
    // so the array sees the live inputs while idle and the latched request otherwise.
    assign w_op_wr = (r_state == StIdle) ? membus_write_i : r_is_wr;
    assign w_idx   = (r_state == StIdle) ? membus_addr_i[OffW +: IdxW] : r_addr[OffW +: IdxW];
    assign w_wdata = (r_state == StIdle) ? membus_wdata_i : r_wdata;

    // Offset and upper address bits deliberately do not affect indexing.
    assign w_unused_addr = ^{membus_addr_i, r_addr};

    // Array is touched only on the edge that enters RESP; gated by rst so an
    // in-flight transaction is dropped cleanly.
    assign w_enter_resp = !rst && (w_state_next == StResp) && (r_state != StResp);

    // State and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    if (latency == 1) begin
                        w_state_next = StResp;
                    end else begin
                        w_state_next = StBusy;
                        w_cnt_next   = CntW'(latency - 1);
                    end
                end
            end
            StBusy: begin
                if (r_cnt == CntW'(1)) begin
                    w_state_next = StResp;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Request latch: captured once on acceptance, ignored until the next IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= membus_addr_i;
            r_wdata <= membus_wdata_i;
            r_is_wr <= membus_write_i;
        end
    end

    membus_mem_array #(
        .Width (line_bits),
        .Depth (depth_lines)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_enter_resp & w_op_wr),
        .i_waddr (w_idx),
        .i_wdata (w_wdata),
        .i_re    (w_enter_resp & ~w_op_wr),
        .i_raddr (w_idx),
        .o_rdata (membus_rdata_o)
    );

    assign membus_resp_o = (r_state == StResp);

`ifdef MEMBUS_PROTO_CHECK_EN
    logic r_proto_err;
    logic w_viol;

    assign w_viol = ((r_state == StIdle) && membus_read_i && membus_write_i) ||
                    ((r_state != StIdle) && w_req &&
                     ((membus_addr_i != r_addr) || (membus_write_i != r_is_wr) ||
                      (membus_wdata_i != r_wdata)));

    // Sticky violation flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (w_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err_o = r_proto_err;
`else
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: doc/membus_mem_responder.md
MEMBUS_MEM_RESPONDER -- requirements
Module: membus_mem_responder

Interface
REQ-001 SHALL have parameter line_bits, default 256, cacheline width in bits (power of two, >=32).
REQ-002 SHALL have parameter depth_lines, default 1024, number of stored lines (power of two, >=2).
REQ-003 SHALL have parameter latency, default 4, cycles from request acceptance to response (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port membus_addr_i  input  32  byte address from membus master.
REQ-007 SHALL have port membus_read_i  input  1  line read request, held until resp.
REQ-008 SHALL have port membus_write_i  input  1  line write request, held until resp.
REQ-009 SHALL have port membus_wdata_i  input  line_bits  write line data.
REQ-010 SHALL have port membus_rdata_o  output  line_bits  read line data, valid when resp_o=1.
REQ-011 SHALL have port membus_resp_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port proto_err_o  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-014 SHALL, in IDLE with read_i|write_i sampled high at edge k, latch addr, wdata and op, load counter with latency-1, and enter BUSY; when latency=1, go directly to RESP.
REQ-015 SHALL, in BUSY, decrement the counter each cycle and enter RESP when it reaches 0 (resp_o high in cycle k+latency).
REQ-016 SHALL assert resp_o only in RESP, for exactly one cycle, then return to IDLE.
REQ-017 SHALL commit a write to the array at the edge entering RESP; a read issued later sees the new data.
REQ-018 SHALL register rdata_o at the edge entering RESP for reads; rdata_o holds its last value otherwise, and writes leave it unchanged.
REQ-019 SHALL index the array with addr[log2(line_bits/8) +: log2(depth_lines)]; offset and upper address bits are ignored (wrap-around).
REQ-020 SHALL ignore input changes during BUSY/RESP and use only the latched request.
REQ-021 SHALL treat read_i and write_i both high as a write.
REQ-022 SHALL, in IDLE in the cycle after RESP, accept a still-high request as a new transaction (back-to-back rate: one transaction per latency+1 cycles).

Reset
REQ-023 SHALL, on rst, immediately force IDLE, resp_o=0, rdata_o=0, proto_err_o=0, counter=0.
REQ-024 SHALL discard a transaction when rst is asserted before its RESP edge; no array write occurs.
REQ-025 SHALL leave array contents unchanged by reset (contents undefined at power-up).

Configuration
REQ-026 SHALL, with MEMBUS_PROTO_CHECK_EN defined, set proto_err_o and hold it until reset on: read_i and write_i both high in IDLE, or addr/op/wdata changing while the latched request is outstanding and read_i|write_i is still high.
REQ-027 SHALL, without MEMBUS_PROTO_CHECK_EN, tie proto_err_o to 0 with no checking logic; all other behaviour is identical.

Structure
REQ-028 SHALL take the cacheline type, membus address width, and FSM state enum from shared package rvga_types.
REQ-029 SHALL place storage in sub-module membus_mem_array (1 read/1 write port, synchronous).

Verification
REQ-030 Reset, then write line 0x5A..5A to addr 0x0000_0040 (latency=4) -> resp_o high exactly 4 cycles after acceptance, for 1 cycle.
REQ-031 Read addr 0x0000_0040 -> rdata_o=0x5A..5A with resp_o; read addr 0x0000_0044 (same line) -> same data.
REQ-032 Write addr 0x0000_0000, then read addr line_bytes*depth_lines -> wrap-around returns the written line.
REQ-033 Assert rst 2 cycles into a write to 0x80 -> resp_o never pulses; a later read of 0x80 returns the prior contents.
REQ-034 With MEMBUS_PROTO_CHECK_EN, drive read_i=write_i=1 -> write performed and proto_err_o=1 until rst; without the macro, proto_err_o stays 0.
REQ-035 Hold read_i high through resp_o for 3 transactions -> resp_o pulses every latency+1 cycles.
